uart_fifo_ctrl: RTL and testbench

Memory-mapped UART controller for the CPU peripheral bus. It replaces the single-byte, dual-clock UART registers with one `sysclk` domain and an integer bit-period divider. It adds parametrised TX/RX FIFOs, configurable data width, optional parity, error flags and a combined interrupt. It sits beside the timer/LED/switch peripheral and decodes its own three-word address window.

---
 rtl/uart_fifo_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// Memory-mapped UART with TX/RX FIFOs, optional parity, sticky errors and one IRQ.
// Everything runs on sysclk; bit timing comes from an integer cycle divider.

module uart_fifo_buf #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module uart_fifo_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0018,
    parameter int          BIT_CYCLES = 5208,
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        txd,
    output logic        irqout
);
    localparam int CW  = $clog2(BIT_CYCLES);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_END  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] C_HALF = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [2:0]    LAST   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } uart_st_t;

    logic sel_tx, sel_rx, sel_con, con_wr;
    assign sel_tx  = addr == BASE_ADDR;
    assign sel_rx  = addr == BASE_ADDR + 32'd4;
    assign sel_con = addr == BASE_ADDR + 32'd8;
    assign con_wr  = wr & sel_con;

    logic [5:0] ctrl;
    logic tx_en, rx_en, par_en, par_odd, rx_irq_en, tx_irq_en;
    assign {tx_irq_en, rx_irq_en, par_odd, par_en, rx_en, tx_en} = ctrl;

    logic overrun, frame_err, par_err;
    logic set_ovr, set_fe, set_pe;

    // A hardware set in the same cycle as a W1C clear wins.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            ctrl      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            if (con_wr) ctrl <= wdata[5:0];
            overrun   <= (overrun & ~(con_wr & wdata[13])) | set_ovr;
            frame_err <= (frame_err & ~(con_wr & wdata[14])) | set_fe;
            par_err   <= (par_err & ~(con_wr & wdata[15])) | set_pe;
        end
    end

    logic                 tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_head;
    logic [FAW:0]         tx_count;
    logic                 rx_push, rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_head;
    logic [FAW:0]         rx_count;

    uart_fifo_buf #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (sysclk),
        .rst   (reset),
        .push  (wr & sel_tx),
        .pop   (tx_pop),
        .din   (wdata[DATA_BITS-1:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    logic [DATA_BITS-1:0] rx_sh;

    uart_fifo_buf #(.DW(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (sysclk),
        .rst   (reset),
        .push  (rx_push),
        .pop   (rd & sel_rx),
        .din   (rx_sh),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    uart_st_t             tx_st, tx_st_n;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [2:0]           tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic                 tx_pb, tx_pb_n;
    logic                 tx_end, tx_load, tx_busy;

    assign tx_end  = tx_cnt == C_END;
    assign tx_busy = tx_st != S_IDLE;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_st  <= S_IDLE;
            tx_cnt <= '0;
            tx_idx <= '0;
            tx_sh  <= '0;
            tx_pb  <= 1'b0;
        end else begin
            tx_st  <= tx_st_n;
            tx_cnt <= tx_cnt_n;
            tx_idx <= tx_idx_n;
            tx_sh  <= tx_sh_n;
            tx_pb  <= tx_pb_n;
        end
    end

    // Loading straight from STOP keeps queued frames back-to-back.
    always_comb begin
        tx_st_n  = tx_st;
        tx_cnt_n = tx_cnt + CW'(1);
        tx_idx_n = tx_idx;
        tx_sh_n  = tx_sh;
        tx_pb_n  = tx_pb;
        tx_pop   = 1'b0;
        tx_load  = 1'b0;
        unique case (tx_st)
            S_IDLE: begin
                tx_cnt_n = '0;
                tx_load  = tx_en & ~tx_empty;
            end
            S_START: if (tx_end) begin
                tx_cnt_n = '0;
                tx_idx_n = '0;
                tx_st_n  = S_DATA;
            end
            S_DATA: if (tx_end) begin
                tx_cnt_n = '0;
                tx_sh_n  = tx_sh >> 1;
                tx_idx_n = tx_idx + 3'd1;
                if (tx_idx == LAST) tx_st_n = par_en ? S_PAR : S_STOP;
            end
            S_PAR: if (tx_end) begin
                tx_cnt_n = '0;
                tx_st_n  = S_STOP;
            end
            S_STOP: if (tx_end) begin
                tx_cnt_n = '0;
                tx_st_n  = S_IDLE;
                tx_load  = tx_en & ~tx_empty;
            end
            default: tx_st_n = S_IDLE;
        endcase
        if (tx_load) begin
            tx_pop  = 1'b1;
            tx_sh_n = tx_head;
            tx_pb_n = ^tx_head;
            tx_st_n = S_START;
        end
    end

    always_comb begin
        txd = 1'b1;
        unique case (tx_st)
            S_START: txd = 1'b0;
            S_DATA:  txd = tx_sh[0];
            S_PAR:   txd = tx_pb ^ par_odd;
            default: txd = 1'b1;
        endcase
    end

    logic rx_m, rx_s, rx_p;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            rx_m <= rxd;
            rx_s <= rx_m;
            rx_p <= rx_s;
        end
    end

    uart_st_t             rx_st, rx_st_n;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [2:0]           rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_sh_n;
    logic                 rx_pbit, rx_pbit_n;
    logic                 rx_end;

    assign rx_end = rx_cnt == C_END;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_st   <= S_IDLE;
            rx_cnt  <= '0;
            rx_idx  <= '0;
            rx_sh   <= '0;
            rx_pbit <= 1'b0;
        end else begin
            rx_st   <= rx_st_n;
            rx_cnt  <= rx_cnt_n;
            rx_idx  <= rx_idx_n;
            rx_sh   <= rx_sh_n;
            rx_pbit <= rx_pbit_n;
        end
    end

    // Samples land mid-bit: half a period into START, then every full period.
    always_comb begin
        rx_st_n   = rx_st;
        rx_cnt_n  = rx_cnt + CW'(1);
        rx_idx_n  = rx_idx;
        rx_sh_n   = rx_sh;
        rx_pbit_n = rx_pbit;
        rx_push   = 1'b0;
        set_ovr   = 1'b0;
        set_fe    = 1'b0;
        set_pe    = 1'b0;
        unique case (rx_st)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_p & ~rx_s) rx_st_n = S_START;
            end
            S_START: if (rx_cnt == C_HALF) begin
                rx_cnt_n = '0;
                rx_idx_n = '0;
                rx_st_n  = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_end) begin
                rx_cnt_n = '0;
                rx_sh_n  = {rx_s, rx_sh[DATA_BITS-1:1]};
                rx_idx_n = rx_idx + 3'd1;
                if (rx_idx == LAST) rx_st_n = par_en ? S_PAR : S_STOP;
            end
            S_PAR: if (rx_end) begin
                rx_cnt_n  = '0;
                rx_pbit_n = rx_s;
                rx_st_n   = S_STOP;
            end
            S_STOP: if (rx_end) begin
                rx_cnt_n = '0;
                rx_st_n  = S_IDLE;
                if (!rx_s) set_fe = 1'b1;
                else if (par_en && (rx_pbit != (^rx_sh ^ par_odd))) set_pe = 1'b1;
                else if (rx_full) set_ovr = 1'b1;
                else rx_push = 1'b1;
            end
            default: rx_st_n = S_IDLE;
        endcase
        if (!rx_en) begin
            rx_st_n  = S_IDLE;
            rx_cnt_n = '0;
            rx_push  = 1'b0;
            set_ovr  = 1'b0;
            set_fe   = 1'b0;
            set_pe   = 1'b0;
        end
    end

    logic [31:0] status;
    assign status = {8'd0, 8'(rx_count), par_err, frame_err, overrun,
                     tx_busy, rx_empty, rx_full, tx_empty, tx_full,
                     2'b00, ctrl};

    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (1'b1)
                sel_rx:  rdata = rx_empty ? '0 : 32'(rx_head);
                sel_con: rdata = status;
                default: rdata = '0;
            endcase
        end
    end

    assign irqout = (rx_irq_en & (~rx_empty | overrun | frame_err | par_err))
                  | (tx_irq_en & tx_empty & ~tx_busy);

    logic unused_bits;
    assign unused_bits = ^{wdata, tx_count};
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: bus tasks, a txd frame decoder and byte scoreboards.

module tb_uart_fifo_ctrl;
    localparam int BC = 16;
    localparam logic [31:0] A_TX  = 32'h4000_0018;
    localparam logic [31:0] A_RX  = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b1;
    logic        rd     = 1'b0;
    logic        wr     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] rdata;
    logic        txd, irqout, rxd;
    logic        rx_drv = 1'b1;
    logic        loop   = 1'b0;
    logic        mon_en = 1'b1;

    int     n_chk = 0;
    int     n_err = 0;
    longint cyc   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    longint     fall_t[$];

    assign rxd = loop ? txd : rx_drv;

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    uart_fifo_ctrl #(
        .BASE_ADDR  (32'h4000_0018),
        .BIT_CYCLES (BC),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .rd     (rd),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rxd    (rxd),
        .txd    (txd),
        .irqout (irqout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] v);
        @(negedge sysclk);
        addr  = a;
        wdata = v;
        wr    = 1'b1;
        @(posedge sysclk);
        #1 wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v);
        @(negedge sysclk);
        addr = a;
        rd   = 1'b1;
        #1 v = rdata;
        @(posedge sysclk);
        #1 rd = 1'b0;
    endtask

    task automatic rx_bit(input logic v);
        @(negedge sysclk);
        rx_drv = v;
        repeat (BC - 1) @(negedge sysclk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par, input bit pbit, input bit stop);
        rx_bit(1'b0);
        for (int i = 0; i < 8; i++) rx_bit(b[i]);
        if (par) rx_bit(pbit);
        rx_bit(stop);
        rx_drv = 1'b1;
        repeat (4) @(negedge sysclk);
    endtask

    task automatic wait_tx_idle(input int limit);
        logic [31:0] d;
        int w;
        w = 0;
        rd_reg(A_CON, d);
        while (!(d[9] && !d[12]) && w < limit) begin
            w++;
            rd_reg(A_CON, d);
        end
        if (w >= limit) chk("tx_idle_timeout", 1, 0);
    endtask

    // Decodes each 8N1 frame on txd and checks it against the TX scoreboard.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge sysclk);
            if (mon_en && txd === 1'b0) begin
                fall_t.push_back(cyc);
                repeat (BC / 2 - 1) @(negedge sysclk);
                chk("tx_start", txd, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BC) @(negedge sysclk);
                    b[i] = txd;
                end
                repeat (BC) @(negedge sysclk);
                chk("tx_stop", txd, 1);
                if (tx_q.size() == 0) chk("tx_extra", 1, 0);
                else chk("tx_byte", b, tx_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #600us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d;
        int w, n, bad;

        repeat (3) @(negedge sysclk);
        chk("rst_txd", txd, 1);
        chk("rst_irq", irqout, 0);
        chk("rst_rdata_idle", rdata, 0);
        reset = 1'b0;
        rd_reg(A_CON, d);
        chk("rst_status", d, 32'h0000_0A00);
        rd_reg(A_TX, d);
        chk("txdata_read", d, 0);
        rd_reg(A_RX, d);
        chk("rx_empty_read", d, 0);
        rd_reg(A_CON + 32'd4, d);
        chk("out_of_window", d, 0);

        wr_reg(A_CON, 32'h20);
        chk("tx_irq", irqout, 1);
        wr_reg(A_CON, 32'h00);
        chk("irq_off", irqout, 0);

        // single 8N1 frame
        wr_reg(A_CON, 32'h01);
        tx_q.push_back(8'hA5);
        wr_reg(A_TX, 32'hA5);
        w = 0;
        rd_reg(A_CON, d);
        while (!d[12] && w < 20) begin
            w++;
            rd_reg(A_CON, d);
        end
        chk("tx_latency", w, 1);
        n = 0;
        while (d[12] && n < 400) begin
            n++;
            rd_reg(A_CON, d);
        end
        chk("tx_busy_len", n, 160);
        chk("tx_done_q", tx_q.size(), 0);

        // loopback
        loop = 1'b1;
        wr_reg(A_CON, 32'h03);
        tx_q.push_back(8'h3C);
        rx_q.push_back(8'h3C);
        wr_reg(A_TX, 32'h3C);
        w = 0;
        rd_reg(A_CON, d);
        while (d[11] && w < 400) begin
            w++;
            rd_reg(A_CON, d);
        end
        chk("loop_wait", w < 400, 1);
        rd_reg(A_RX, d);
        chk("loop_rx", d, rx_q.pop_front());
        rd_reg(A_CON, d);
        chk("loop_rx_empty", d[11], 1);
        wait_tx_idle(400);
        loop = 1'b0;

        // TX FIFO full, then drain back-to-back
        wr_reg(A_CON, 32'h00);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_q.push_back(8'(i));
            wr_reg(A_TX, 32'(i));
        end
        rd_reg(A_CON, d);
        chk("tx_full", d[9:8], 2'b01);
        fall_t.delete();
        wr_reg(A_CON, 32'h01);
        wait_tx_idle(3000);
        chk("fifo_frames", fall_t.size(), 16);
        bad = 0;
        for (int i = 1; i < fall_t.size(); i++)
            if (fall_t[i] - fall_t[i-1] != 160) bad++;
        chk("fifo_gap", bad, 0);
        chk("fifo_q", tx_q.size(), 0);

        // RX overrun
        wr_reg(A_CON, 32'h02);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_q.push_back(8'h40 + 8'(i));
            send_frame(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        end
        rd_reg(A_CON, d);
        chk("ovr_status", d, 32'h0010_2602);
        for (int i = 0; i < 16; i++) begin
            rd_reg(A_RX, d);
            chk("ovr_data", d, rx_q.pop_front());
        end
        rd_reg(A_CON, d);
        chk("ovr_after_read", d, 32'h0000_2A02);
        wr_reg(A_CON, 32'h2002);
        rd_reg(A_CON, d);
        chk("ovr_clear", d, 32'h0000_0A02);

        // parity and framing
        wr_reg(A_CON, 32'h06);
        rx_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        rd_reg(A_RX, d);
        chk("par_good", d, rx_q.pop_front());
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        rd_reg(A_CON, d);
        chk("par_err", d, 32'h0000_8A06);
        send_frame(8'h55, 1'b1, 1'b0, 1'b0);
        rd_reg(A_CON, d);
        chk("frame_err", d, 32'h0000_CA06);
        chk("irq_masked", irqout, 0);
        wr_reg(A_CON, 32'h16);
        chk("irq_err", irqout, 1);
        wr_reg(A_CON, 32'h8016);
        chk("irq_one_left", irqout, 1);
        wr_reg(A_CON, 32'h4016);
        chk("irq_cleared", irqout, 0);
        rd_reg(A_CON, d);
        chk("err_cleared", d, 32'h0000_0A16);

        // 4-cycle glitch on rxd
        wr_reg(A_CON, 32'h02);
        @(negedge sysclk);
        rx_drv = 1'b0;
        repeat (4) @(negedge sysclk);
        rx_drv = 1'b1;
        repeat (40) @(negedge sysclk);
        rd_reg(A_CON, d);
        chk("glitch", d, 32'h0000_0A02);

        // reset mid-frame
        mon_en = 1'b0;
        wr_reg(A_CON, 32'h01);
        wr_reg(A_TX, 32'h00);
        repeat (40) @(negedge sysclk);
        chk("pre_reset_txd", txd, 0);
        reset = 1'b1;
        #1;
        chk("reset_txd", txd, 1);
        rd_reg(A_CON, d);
        chk("reset_status", d, 32'h0000_0A00);
        reset = 1'b0;
        repeat (20) @(negedge sysclk);
        chk("post_reset_txd", txd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
